// File: rtl/reservation_station_if.sv
// Issue, LSB snoop and result buses of the reservation station.
// slave is the station side; master is the Decoder/LSB/RoB side.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef R_TYPE
`define R_TYPE 7'b0110011
`endif
`ifndef I_TYPE
`define I_TYPE 7'b0010011
`endif
`ifndef B_TYPE
`define B_TYPE 7'b1100011
`endif

interface reservation_station_if #(
    parameter int ROB_W = `ROB_SIZE_WIDTH
);
    logic             rs_full;
    logic             issue_rs;
    logic [6:0]       instr_type;
    logic [2:0]       op;
    logic             funct7_5;
    logic [ROB_W-1:0] issue_rob;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic             qj_busy;
    logic             qk_busy;
    logic             lsb_ready;
    logic [ROB_W-1:0] lsb_rob_id;
    logic [31:0]      lsb_value;
    logic             rs_ready;
    logic [ROB_W-1:0] rs_rob_id;
    logic [31:0]      rs_value;

    modport slave (
        output rs_full, rs_ready, rs_rob_id, rs_value,
        input  issue_rs, instr_type, op, funct7_5, issue_rob, vj, vk, qj, qk,
               qj_busy, qk_busy, lsb_ready, lsb_rob_id, lsb_value
    );

    modport master (
        input  rs_full, rs_ready, rs_rob_id, rs_value,
        output issue_rs, instr_type, op, funct7_5, issue_rob, vj, vk, qj, qk,
               qj_busy, qk_busy, lsb_ready, lsb_rob_id, lsb_value
    );
endinterface

// File: rtl/reservation_station.sv
// ALU/branch reservation station: holds issued ops until operands resolve,
// executes the lowest-index ready entry each cycle and broadcasts the result.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef R_TYPE
`define R_TYPE 7'b0110011
`endif
`ifndef I_TYPE
`define I_TYPE 7'b0010011
`endif
`ifndef B_TYPE
`define B_TYPE 7'b1100011
`endif

module reservation_station #(
    parameter int RS_SIZE       = 8,
    parameter int RS_SIZE_WIDTH = 3,
    parameter int ROB_W         = `ROB_SIZE_WIDTH
) (
    input logic clk,
    input logic rst,
    input logic rdy,
    input logic clear,
    reservation_station_if.slave bus
);
    typedef struct packed {
        logic [6:0]       itype;
        logic [2:0]       op;
        logic             f7;
        logic [ROB_W-1:0] rob;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [ROB_W-1:0] qj;
        logic [ROB_W-1:0] qk;
        logic             jp;
        logic             kp;
    } entry_t;

    entry_t                   ent     [RS_SIZE];
    entry_t                   wk      [RS_SIZE];
    entry_t                   ent_nxt [RS_SIZE];
    entry_t                   inc;
    logic [RS_SIZE-1:0]       busy, busy_nxt, ready_vec;
    logic [RS_SIZE_WIDTH-1:0] free_idx, dsp_idx;
    logic                     dsp_vld, full, take;
    logic [31:0]              result;
    logic                     res_vld;
    logic [ROB_W-1:0]         res_rob;
    logic [31:0]              res_val;

    // Capture any pending operand whose producer tag is on either bus this cycle.
    function automatic entry_t wake(input entry_t e,
                                    input logic av, input logic [ROB_W-1:0] at, input logic [31:0] ad,
                                    input logic bv, input logic [ROB_W-1:0] bt, input logic [31:0] bd);
        entry_t w;
        w = e;
        if (e.jp && av && at == e.qj) begin
            w.vj = ad; w.jp = 1'b0;
        end else if (e.jp && bv && bt == e.qj) begin
            w.vj = bd; w.jp = 1'b0;
        end
        if (e.kp && av && at == e.qk) begin
            w.vk = ad; w.kp = 1'b0;
        end else if (e.kp && bv && bt == e.qk) begin
            w.vk = bd; w.kp = 1'b0;
        end
        return w;
    endfunction

    function automatic logic [31:0] exec(input entry_t e);
        logic [4:0]         sh;
        logic               lt, ltu;
        logic signed [31:0] sra;
        logic [31:0]        r;
        sh  = e.vk[4:0];
        lt  = $signed(e.vj) < $signed(e.vk);
        ltu = e.vj < e.vk;
        sra = $signed(e.vj) >>> sh;
        r   = '0;
        if (e.itype == `B_TYPE) begin
            case (e.op)
                3'b000:  r = {31'b0, e.vj == e.vk};
                3'b001:  r = {31'b0, e.vj != e.vk};
                3'b100:  r = {31'b0, lt};
                3'b101:  r = {31'b0, !lt};
                3'b110:  r = {31'b0, ltu};
                3'b111:  r = {31'b0, !ltu};
                default: r = '0;
            endcase
        end else begin
            case (e.op)
                3'b000:  r = (e.itype == `R_TYPE && e.f7) ? e.vj - e.vk : e.vj + e.vk;
                3'b001:  r = e.vj << sh;
                3'b010:  r = {31'b0, lt};
                3'b011:  r = {31'b0, ltu};
                3'b100:  r = e.vj ^ e.vk;
                3'b101:  r = e.f7 ? sra : e.vj >> sh;
                3'b110:  r = e.vj | e.vk;
                default: r = e.vj & e.vk;
            endcase
        end
        return r;
    endfunction

    // Wake-up is forwarded into selection so a dependent op dispatches
    // in the cycle its producer's result is on the bus.
    always_comb begin
        inc          = '0;
        inc.itype    = bus.instr_type;
        inc.op       = bus.op;
        inc.f7       = bus.funct7_5;
        inc.rob      = bus.issue_rob;
        inc.vj       = bus.vj;
        inc.vk       = bus.vk;
        inc.qj       = bus.qj;
        inc.qk       = bus.qk;
        inc.jp       = bus.qj_busy;
        inc.kp       = bus.qk_busy;
        inc = wake(inc, res_vld, res_rob, res_val, bus.lsb_ready, bus.lsb_rob_id, bus.lsb_value);
        for (int i = 0; i < RS_SIZE; i++)
            wk[i] = wake(ent[i], res_vld, res_rob, res_val, bus.lsb_ready, bus.lsb_rob_id, bus.lsb_value);
    end

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_ready
        assign ready_vec[g] = busy[g] && !wk[g].jp && !wk[g].kp;
    end

    always_comb begin
        free_idx = '0;
        dsp_idx  = '0;
        dsp_vld  = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = RS_SIZE_WIDTH'(i);
            if (ready_vec[i]) begin
                dsp_idx = RS_SIZE_WIDTH'(i);
                dsp_vld = 1'b1;
            end
        end
    end

    assign full   = &busy;
    assign take   = bus.issue_rs && !full;
    assign result = exec(wk[dsp_idx]);

    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < RS_SIZE; i++) ent_nxt[i] = wk[i];
        if (dsp_vld) busy_nxt[dsp_idx] = 1'b0;
        if (take) begin
            busy_nxt[free_idx] = 1'b1;
            ent_nxt[free_idx]  = inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= '0;
            res_vld <= 1'b0;
            res_rob <= '0;
            res_val <= '0;
        end else if (rdy) begin
            if (clear) begin
                busy    <= '0;
                res_vld <= 1'b0;
            end else begin
                busy    <= busy_nxt;
                res_vld <= dsp_vld;
                if (dsp_vld) begin
                    res_rob <= wk[dsp_idx].rob;
                    res_val <= result;
                end
            end
        end
    end

    // Payload needs no reset: busy alone qualifies every entry.
    always_ff @(posedge clk) begin
        if (rdy && !clear) ent <= ent_nxt;
    end

    assign bus.rs_full   = full;
    assign bus.rs_ready  = res_vld;
    assign bus.rs_rob_id = res_rob;
    assign bus.rs_value  = res_val;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: vector table plus hand sequences,
// with every broadcast result checked against a scoreboard queue.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef R_TYPE
`define R_TYPE 7'b0110011
`endif
`ifndef I_TYPE
`define I_TYPE 7'b0010011
`endif
`ifndef B_TYPE
`define B_TYPE 7'b1100011
`endif

module tb_reservation_station;
    localparam int ROB_W = `ROB_SIZE_WIDTH;

    logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, clear = 1'b0;

    reservation_station_if #(.ROB_W(ROB_W)) bus();

    reservation_station #(.RS_SIZE(8), .RS_SIZE_WIDTH(3), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ROB_W-1:0] rob;
        logic [31:0]      val;
    } res_t;

    typedef struct {
        logic [6:0]  t;
        logic [2:0]  op;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    int   checks = 0, failures = 0;
    res_t exp_q[$];
    logic last_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int rob, input logic [31:0] v);
        res_t r;
        r.rob = ROB_W'(rob);
        r.val = v;
        exp_q.push_back(r);
    endtask

    task automatic issue(input logic [6:0] t, input logic [2:0] o, input logic f, input int rob,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic bj, input int tj, input logic bk, input int tk);
        bus.issue_rs   = 1'b1;
        bus.instr_type = t;
        bus.op         = o;
        bus.funct7_5   = f;
        bus.issue_rob  = ROB_W'(rob);
        bus.vj         = a;
        bus.vk         = b;
        bus.qj_busy    = bj;
        bus.qj         = ROB_W'(tj);
        bus.qk_busy    = bk;
        bus.qk         = ROB_W'(tk);
        tick();
        bus.issue_rs = 1'b0;
        bus.qj_busy  = 1'b0;
        bus.qk_busy  = 1'b0;
    endtask

    task automatic lsb_on(input int tag, input logic [31:0] v);
        bus.lsb_ready  = 1'b1;
        bus.lsb_rob_id = ROB_W'(tag);
        bus.lsb_value  = v;
    endtask

    task automatic wait_res(input string name);
        int n;
        n = 0;
        while (!bus.rs_ready && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.rs_ready) begin
            failures++;
            $display("FAIL %s: rs_ready=0 after 10 cycles, required 1", name);
        end
    endtask

    // A result is fresh only if the edge that produced it had rdy high.
    always @(posedge clk) last_rdy <= rdy;

    always @(negedge clk) begin
        if (!rst && last_rdy && bus.rs_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: rob=%0d value=%h, required no result", bus.rs_rob_id, bus.rs_value);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("result_rob", 32'(bus.rs_rob_id), 32'(e.rob));
                check("result_value", bus.rs_value, e.val);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [20];
        vecs[0]  = '{`R_TYPE, 3'b000, 1'b0, 32'd5,         32'd7,         32'd12};
        vecs[1]  = '{`R_TYPE, 3'b000, 1'b1, 32'd5,         32'd7,         32'hFFFF_FFFE};
        vecs[2]  = '{`R_TYPE, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[3]  = '{`R_TYPE, 3'b001, 1'b0, 32'd1,         32'h23,        32'd8};
        vecs[4]  = '{`R_TYPE, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd1};
        vecs[5]  = '{`R_TYPE, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[6]  = '{`R_TYPE, 3'b100, 1'b0, 32'hF0F0,      32'h0FF0,      32'hFF00};
        vecs[7]  = '{`R_TYPE, 3'b101, 1'b0, 32'h8000_0000, 32'd4,         32'h0800_0000};
        vecs[8]  = '{`R_TYPE, 3'b101, 1'b1, 32'h8000_0000, 32'd4,         32'hF800_0000};
        vecs[9]  = '{`R_TYPE, 3'b110, 1'b0, 32'hF0,        32'h0F,        32'hFF};
        vecs[10] = '{`R_TYPE, 3'b111, 1'b0, 32'hF0,        32'h3C,        32'h30};
        vecs[11] = '{`I_TYPE, 3'b000, 1'b1, 32'd10,        32'd3,         32'd13};
        vecs[12] = '{`I_TYPE, 3'b101, 1'b1, 32'hFFFF_FF00, 32'd4,         32'hFFFF_FFF0};
        vecs[13] = '{`B_TYPE, 3'b000, 1'b0, 32'd4,         32'd4,         32'd1};
        vecs[14] = '{`B_TYPE, 3'b001, 1'b0, 32'd4,         32'd4,         32'd0};
        vecs[15] = '{`B_TYPE, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd1};
        vecs[16] = '{`B_TYPE, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[17] = '{`B_TYPE, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[18] = '{`B_TYPE, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd1};
        vecs[19] = '{`I_TYPE, 3'b010, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1};

        bus.issue_rs = 1'b0; bus.instr_type = '0; bus.op = '0; bus.funct7_5 = 1'b0;
        bus.issue_rob = '0; bus.vj = '0; bus.vk = '0; bus.qj = '0; bus.qk = '0;
        bus.qj_busy = 1'b0; bus.qk_busy = 1'b0;
        bus.lsb_ready = 1'b0; bus.lsb_rob_id = '0; bus.lsb_value = '0;

        repeat (3) tick();
        rst = 1'b0;
        chk1("reset_rs_ready", bus.rs_ready, 1'b0);
        check("reset_rs_rob_id", 32'(bus.rs_rob_id), 32'd0);
        check("reset_rs_value", bus.rs_value, 32'd0);
        chk1("reset_rs_full", bus.rs_full, 1'b0);

        // Latency: issue at edge N, result valid after edge N+1 for one cycle.
        push(3, 32'd12);
        issue(`R_TYPE, 3'b000, 1'b0, 3, 32'd5, 32'd7, 1'b0, 0, 1'b0, 0);
        chk1("lat_edge_n", bus.rs_ready, 1'b0);
        tick();
        chk1("lat_edge_n1", bus.rs_ready, 1'b1);
        check("lat_rob", 32'(bus.rs_rob_id), 32'd3);
        check("lat_value", bus.rs_value, 32'd12);
        tick();
        chk1("lat_one_cycle", bus.rs_ready, 1'b0);

        for (int i = 0; i < 20; i++) begin
            push(i % 16, vecs[i].exp);
            issue(vecs[i].t, vecs[i].op, vecs[i].f7, i % 16, vecs[i].a, vecs[i].b, 1'b0, 0, 1'b0, 0);
        end
        repeat (3) tick();

        // LSB wake-up of a pending SUB.
        push(4, 32'hF);
        issue(`R_TYPE, 3'b000, 1'b1, 4, 32'hDEAD, 32'd1, 1'b1, 2, 1'b0, 0);
        tick();
        chk1("lsb_pending", bus.rs_ready, 1'b0);
        lsb_on(2, 32'h10);
        tick();
        bus.lsb_ready = 1'b0;
        wait_res("lsb_wakeup");
        tick();

        // Issue bypass from the LSB bus and from the station's own bus.
        push(5, 32'h21);
        lsb_on(6, 32'h20);
        issue(`R_TYPE, 3'b000, 1'b0, 5, 32'hBAD, 32'd1, 1'b1, 6, 1'b0, 0);
        bus.lsb_ready = 1'b0;
        wait_res("bypass_lsb");
        tick();
        push(1, 32'd3);
        issue(`R_TYPE, 3'b000, 1'b0, 1, 32'd1, 32'd2, 1'b0, 0, 1'b0, 0);
        tick();
        push(2, 32'd13);
        issue(`R_TYPE, 3'b000, 1'b0, 2, 32'd0, 32'd10, 1'b1, 1, 1'b0, 0);
        wait_res("bypass_rs");
        tick();

        // Dependent chain: one result per cycle.
        push(1, 32'd3);
        issue(`R_TYPE, 3'b000, 1'b0, 1, 32'd1, 32'd2, 1'b0, 0, 1'b0, 0);
        push(2, 32'd13);
        issue(`R_TYPE, 3'b000, 1'b0, 2, 32'd0, 32'd10, 1'b1, 1, 1'b0, 0);
        chk1("chain_a", bus.rs_ready, 1'b1);
        push(3, 32'd23);
        issue(`R_TYPE, 3'b000, 1'b0, 3, 32'd0, 32'd10, 1'b1, 2, 1'b0, 0);
        chk1("chain_b", bus.rs_ready, 1'b1);
        tick();
        chk1("chain_c", bus.rs_ready, 1'b1);
        tick();
        chk1("chain_done", bus.rs_ready, 1'b0);

        // Fill all eight entries pending on tag 7; a ninth issue must be ignored.
        for (int i = 0; i < 8; i++) begin
            push(8 + i, 32'(100 + i));
            issue(`R_TYPE, 3'b000, 1'b0, 8 + i, 32'(i), 32'd0, 1'b0, 0, 1'b1, 7);
        end
        chk1("full_set", bus.rs_full, 1'b1);
        issue(`R_TYPE, 3'b000, 1'b0, 5, 32'd1, 32'd1, 1'b0, 0, 1'b0, 0);
        chk1("full_hold", bus.rs_full, 1'b1);
        tick();
        chk1("full_ninth_ignored", bus.rs_ready, 1'b0);
        lsb_on(7, 32'd100);
        tick();
        bus.lsb_ready = 1'b0;
        wait_res("full_first");
        for (int k = 0; k < 8; k++) begin
            chk1("full_stream", bus.rs_ready, 1'b1);
            tick();
        end
        chk1("full_drained", bus.rs_ready, 1'b0);
        chk1("full_released", bus.rs_full, 1'b0);

        // Clear frees all entries and drops a same-cycle issue.
        for (int i = 0; i < 3; i++)
            issue(`R_TYPE, 3'b000, 1'b0, i, 32'd0, 32'd0, 1'b1, 9, 1'b0, 0);
        clear = 1'b1;
        issue(`R_TYPE, 3'b000, 1'b0, 1, 32'd1, 32'd1, 1'b0, 0, 1'b0, 0);
        clear = 1'b0;
        chk1("clear_no_ready", bus.rs_ready, 1'b0);
        for (int i = 0; i < 5; i++)
            issue(`R_TYPE, 3'b000, 1'b0, 3 + i, 32'd0, 32'd0, 1'b1, 10, 1'b0, 0);
        chk1("clear_freed", bus.rs_full, 1'b0);
        lsb_on(9, 32'd55);
        tick();
        bus.lsb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("clear_old_tag", bus.rs_ready, 1'b0);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk1("clear_empty", bus.rs_full, 1'b0);

        // rdy low: outputs hold, no dispatch, broadcasts ignored.
        issue(`R_TYPE, 3'b000, 1'b0, 13, 32'd0, 32'd2, 1'b1, 12, 1'b0, 0);
        push(1, 32'd2);
        issue(`R_TYPE, 3'b000, 1'b0, 1, 32'd1, 32'd1, 1'b0, 0, 1'b0, 0);
        push(2, 32'd6);
        issue(`R_TYPE, 3'b000, 1'b0, 2, 32'd3, 32'd3, 1'b0, 0, 1'b0, 0);
        chk1("rdy_pre", bus.rs_ready, 1'b1);
        rdy = 1'b0;
        lsb_on(12, 32'h40);
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.lsb_ready = 1'b0;
            chk1("rdy_hold_ready", bus.rs_ready, 1'b1);
            check("rdy_hold_value", bus.rs_value, 32'd2);
        end
        rdy = 1'b1;
        tick();
        chk1("rdy_resume", bus.rs_ready, 1'b1);
        check("rdy_resume_value", bus.rs_value, 32'd6);
        tick();
        chk1("rdy_no_wake", bus.rs_ready, 1'b0);
        push(13, 32'h42);
        lsb_on(12, 32'h40);
        tick();
        bus.lsb_ready = 1'b0;
        wait_res("rdy_late_wake");
        tick();

        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                tick();
                n++;
            end
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
